// File: rtl/disp_pkg.sv
// Shared display constants for the 7-segment scanner: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the GAP/SHOW slot-state encoding.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry n is the pattern for decimal digit n
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    SLOT_GAP,
    SLOT_SHOW
  } slot_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display scanner with per-frame snapshot,
// anti-ghosting gap and blinking colon. Optional macro LEADING_ZERO_BLANK_EN.
module seg7_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_q [4];
  logic [3:0]    snap_d [4];
  logic          blink_q, blink_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          slot_end;
  slot_t         slot;
  logic [3:0]    shown_digit;
  logic [6:0]    digit_seg;

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    blink_d  = blink_q ^ CE;
    frame_d  = slot_end && (idx_q == 2'd3);
    snap_d   = snap_q;
    // Capture all digits together at the frame boundary so a frame never tears
    if (frame_d) begin
      snap_d[0] = D0;
      snap_d[1] = D1;
      snap_d[2] = D2;
      snap_d[3] = D3;
    end
  end

  assign shown_digit = snap_d[idx_d];

  bcd_to_seg7 u_dec (
    .bcd (shown_digit),
    .seg (digit_seg)
  );

  // Outputs are decoded from next-state values so they register glitch-free
  always_comb begin
    slot = (cnt_d < GAP_END) ? SLOT_GAP : SLOT_SHOW;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_d == 2'd3) && (snap_d[3] == 4'd0)) begin
      slot = SLOT_GAP;
    end
`endif
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (slot == SLOT_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = digit_seg;
      dp_d        = !((idx_d == 2'd2) && blink_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '{default: 4'd0};
      blink_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
